// File: rtl/control_mc.sv
// Multi-cycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory ready
// handshake, a wait-state timeout, and a sticky trap on illegal opcodes or bus timeout.
`timescale 1ns/1ps
module control_mc #(
  parameter int OPCODE_W    = 4,
  parameter int ALU_W       = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                Eq,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                instruction_flag,
  output logic                pc_flag,
  output logic                change_address_flag,
  output logic                Wr_en_rf,
  output logic                Wr_en,
  output logic                M13,
  output logic                M2,
  output logic                M457,
  output logic                M6,
  output logic [ALU_W-1:0]    ALU,
  output logic [2:0]          state,
  output logic                timeout,
  output logic                illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  // The last wait cycle that may still be absorbed; one more miss traps.
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             illegal_q, illegal_d;

  logic       waiting, wait_hit, dec_valid;
  logic [3:0] dec_op;

  function automatic logic op_illegal(input logic [OPCODE_W-1:0] op);
    return (op >> 4) != '0;
  endfunction

  function automatic logic [3:0] alu_code(input logic [3:0] op);
    case (op)
      4'hC, 4'hE, 4'hF: return 4'd4;
      4'h8, 4'h9:       return 4'd5;
      4'h7:             return 4'd0;
      default:          return op;
    endcase
  endfunction

  always_comb begin
    state_d             = state_q;
    op_d                = op_q;
    cnt_d               = cnt_q;
    timeout_d           = timeout_q;
    illegal_d           = illegal_q;
    mem_req             = 1'b0;
    instruction_flag    = 1'b0;
    pc_flag             = 1'b0;
    change_address_flag = 1'b0;
    Wr_en_rf            = 1'b0;
    Wr_en               = 1'b0;
    M13                 = 1'b0;
    M2                  = 1'b0;
    M457                = 1'b0;
    M6                  = 1'b0;
    ALU                 = '0;

    waiting  = (state_q == S_FETCH) || (state_q == S_MEM);
    wait_hit = waiting && !mem_ready && (MEM_TIMEOUT != 0) && (cnt_q >= TO_LIM);

    case (state_q)
      S_FETCH: begin
        mem_req          = 1'b1;
        instruction_flag = 1'b1;
        pc_flag          = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_hit) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end
      S_DECODE: begin
        op_d = opcode[3:0];
        if (op_illegal(opcode)) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          4'h7: begin change_address_flag = 1'b1; state_d = S_FETCH; end
          4'h8: begin change_address_flag = Eq;   state_d = S_FETCH; end
          4'h9: begin change_address_flag = !Eq;  state_d = S_FETCH; end
          4'h6:       state_d = S_FETCH;
          4'hE, 4'hF: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        Wr_en   = (op_q == 4'hF);
        if (mem_ready) begin
          state_d = (op_q == 4'hF) ? S_FETCH : S_WB;
        end else if (wait_hit) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end
      S_WB: begin
        Wr_en_rf = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase

    // Wait counter: restarts on every state change, saturates instead of wrapping.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (waiting && !mem_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end

    // In DECODE the selects look ahead at the incoming opcode.
    dec_op    = (state_q == S_DECODE) ? opcode[3:0] : op_q;
    dec_valid = ((state_q == S_DECODE) && !op_illegal(opcode)) ||
                (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);
    if (dec_valid) begin
      M13  = (dec_op == 4'hC) || (dec_op == 4'hD) || (dec_op == 4'hE);
      M2   = (dec_op >= 4'hA);
      M457 = (dec_op == 4'hD);
      M6   = (dec_op == 4'hE);
      ALU  = ALU_W'(alu_code(dec_op));
    end

    // Everything driven low while reset is held, so an access is dropped at once.
    if (!reset) begin
      mem_req             = 1'b0;
      instruction_flag    = 1'b0;
      pc_flag             = 1'b0;
      change_address_flag = 1'b0;
      Wr_en_rf            = 1'b0;
      Wr_en               = 1'b0;
      M13                 = 1'b0;
      M2                  = 1'b0;
      M457                = 1'b0;
      M6                  = 1'b0;
      ALU                 = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      illegal_q <= illegal_d;
    end
  end

  assign state   = state_q;
  assign timeout = timeout_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_control_mc.sv
// Directed bench for control_mc: reset, ALU/branch/load/store flows, timeout and illegal traps.
`timescale 1ns/1ps
module tb_control_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, reset2, Eq, mem_ready;
  logic [3:0] opcode;
  logic [4:0] opcode5;

  logic       mem_req, instruction_flag, pc_flag, caf, wr_en_rf, wr_en, m13, m2, m457, m6;
  logic [3:0] alu;
  logic [2:0] state;
  logic       timeout, illegal;

  logic       mem_req5, instruction_flag5, pc_flag5, caf5, wr_en_rf5, wr_en5, m13_5, m2_5, m457_5, m6_5;
  logic [3:0] alu5;
  logic [2:0] state5;
  logic       timeout5, illegal5;

  int n_checks = 0;
  int n_fail   = 0;

  control_mc u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .Eq(Eq), .mem_ready(mem_ready),
    .mem_req(mem_req), .instruction_flag(instruction_flag), .pc_flag(pc_flag),
    .change_address_flag(caf), .Wr_en_rf(wr_en_rf), .Wr_en(wr_en),
    .M13(m13), .M2(m2), .M457(m457), .M6(m6), .ALU(alu), .state(state),
    .timeout(timeout), .illegal(illegal)
  );

  control_mc #(.OPCODE_W(5)) u_dut5 (
    .clk(clk), .reset(reset2), .opcode(opcode5), .Eq(Eq), .mem_ready(mem_ready),
    .mem_req(mem_req5), .instruction_flag(instruction_flag5), .pc_flag(pc_flag5),
    .change_address_flag(caf5), .Wr_en_rf(wr_en_rf5), .Wr_en(wr_en5),
    .M13(m13_5), .M2(m2_5), .M457(m457_5), .M6(m6_5), .ALU(alu5), .state(state5),
    .timeout(timeout5), .illegal(illegal5)
  );

  task automatic next_cycle;
    @(posedge clk);
    #2;
  endtask

  // Leaves both DUTs in FETCH, mid-cycle, with the wait counter at zero.
  task automatic do_reset;
    @(posedge clk);
    #2;
    reset = 1'b0; reset2 = 1'b0; mem_ready = 1'b0; Eq = 1'b0; opcode = 4'd0; opcode5 = 5'd0;
    @(posedge clk);
    #2;
    reset = 1'b1; reset2 = 1'b1;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #2;
    reset = 1'b0; mem_ready = 1'b1;
    #1;
    n_checks++;
    if (state !== 3'd0 || mem_req !== 1'b0 || pc_flag !== 1'b0 || timeout !== 1'b0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: state=%0d mem_req=%b pc_flag=%b timeout=%b illegal=%b, required 0 0 0 0 0",
               state, mem_req, pc_flag, timeout, illegal);
    end
    mem_ready = 1'b0;
    next_cycle;
    reset = 1'b1;
    #1;
    n_checks++;
    if (state !== 3'd0 || mem_req !== 1'b1 || pc_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: state=%0d mem_req=%b pc_flag=%b, required 0 1 0", state, mem_req, pc_flag);
    end
    // SW, interrupted by reset while waiting in MEM
    mem_ready = 1'b1; opcode = 4'hF;
    #1;
    n_checks++;
    if (pc_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_fetch_pc: pc_flag=%b, required 1", pc_flag);
    end
    next_cycle;
    mem_ready = 1'b0;
    next_cycle;
    next_cycle;
    #1;
    n_checks++;
    if (state !== 3'd3 || wr_en !== 1'b1 || mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_mem: state=%0d Wr_en=%b mem_req=%b, required 3 1 1", state, wr_en, mem_req);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd0 || wr_en !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_mem: state=%0d Wr_en=%b mem_req=%b, required 0 0 0", state, wr_en, mem_req);
    end
    next_cycle;
    reset = 1'b1;
    #1;
    n_checks++;
    if (state !== 3'd0 || pc_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL after_abort: state=%0d pc_flag=%b, required 0 0", state, pc_flag);
    end
  endtask

  task automatic test_add;
    logic [2:0] exp_st [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    int pc_cnt = 0;
    int wr_cnt = 0;
    do_reset;
    mem_ready = 1'b1; opcode = 4'h4;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle;
      #1;
      n_checks++;
      if (state !== exp_st[i]) begin
        n_fail++;
        $display("FAIL add_state[%0d]: state=%0d, required %0d", i, state, exp_st[i]);
      end
      if (i == 2 || i == 3) begin
        n_checks++;
        if (alu !== 4'd4) begin
          n_fail++;
          $display("FAIL add_alu[%0d]: ALU=%0d, required 4", i, alu);
        end
      end
      if (i < 4 && pc_flag === 1'b1) pc_cnt++;
      if (wr_en_rf === 1'b1) wr_cnt++;
    end
    n_checks++;
    if (pc_cnt != 1 || wr_cnt != 1) begin
      n_fail++;
      $display("FAIL add_pulses: pc_flag pulses=%0d Wr_en_rf pulses=%0d, required 1 1", pc_cnt, wr_cnt);
    end
  endtask

  task automatic run_branch(input logic [3:0] op, input logic eq, input logic exp_caf);
    logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
    int wr_cnt = 0;
    do_reset;
    mem_ready = 1'b1; opcode = op; Eq = eq;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle;
      #1;
      n_checks++;
      if (state !== exp_st[i]) begin
        n_fail++;
        $display("FAIL br_state op=%0h[%0d]: state=%0d, required %0d", op, i, state, exp_st[i]);
      end
      if (i == 2) begin
        n_checks++;
        if (caf !== exp_caf || alu !== 4'd5) begin
          n_fail++;
          $display("FAIL br_exec op=%0h Eq=%b: caf=%b ALU=%0d, required %b 5", op, eq, caf, alu, exp_caf);
        end
      end
      if (wr_en_rf === 1'b1) wr_cnt++;
    end
    n_checks++;
    if (wr_cnt != 0) begin
      n_fail++;
      $display("FAIL br_no_wb op=%0h: Wr_en_rf pulses=%0d, required 0", op, wr_cnt);
    end
  endtask

  task automatic test_branch;
    run_branch(4'h8, 1'b1, 1'b1);
    run_branch(4'h8, 1'b0, 1'b0);
    run_branch(4'h9, 1'b0, 1'b1);
  endtask

  task automatic test_lw;
    logic [2:0] exp_st [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    do_reset;
    opcode = 4'hE;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cycle;
      mem_ready = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
      #1;
      n_checks++;
      if (state !== exp_st[i]) begin
        n_fail++;
        $display("FAIL lw_state[%0d]: state=%0d, required %0d", i, state, exp_st[i]);
      end
      if (i == 4) begin
        n_checks++;
        if (mem_req !== 1'b1 || wr_en !== 1'b0) begin
          n_fail++;
          $display("FAIL lw_mem: mem_req=%b Wr_en=%b, required 1 0", mem_req, wr_en);
        end
      end
      if (i == 7) begin
        n_checks++;
        if (m6 !== 1'b1 || m13 !== 1'b1 || m2 !== 1'b1 || alu !== 4'd4 || wr_en_rf !== 1'b1) begin
          n_fail++;
          $display("FAIL lw_wb: M6=%b M13=%b M2=%b ALU=%0d Wr_en_rf=%b, required 1 1 1 4 1",
                   m6, m13, m2, alu, wr_en_rf);
        end
      end
    end
  endtask

  task automatic test_timeout;
    int bad = 0;
    do_reset;
    mem_ready = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) next_cycle;
      #1;
      if (state !== 3'd0 || timeout !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL to_wait: early leave from FETCH in %0d cycles, required 0", bad);
    end
    next_cycle;
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (state !== 3'd7 || timeout !== 1'b1 || illegal !== 1'b0 || mem_req !== 1'b0 || pc_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL to_trap: state=%0d timeout=%b illegal=%b mem_req=%b pc_flag=%b, required 7 1 0 0 0",
               state, timeout, illegal, mem_req, pc_flag);
    end
    do_reset;
    mem_ready = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) next_cycle;
    end
    next_cycle;
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (pc_flag !== 1'b1 || state !== 3'd0) begin
      n_fail++;
      $display("FAIL to_last_ready: state=%0d pc_flag=%b, required 0 1", state, pc_flag);
    end
    next_cycle;
    #1;
    n_checks++;
    if (state !== 3'd1 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL to_no_trap: state=%0d timeout=%b, required 1 0", state, timeout);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] exp_st [9] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    do_reset;
    mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) next_cycle;
      opcode = (i < 4) ? 4'hD : 4'hF;
      #1;
      n_checks++;
      if (state !== exp_st[i]) begin
        n_fail++;
        $display("FAIL b2b_state[%0d]: state=%0d, required %0d", i, state, exp_st[i]);
      end
      if (i == 2) begin
        n_checks++;
        if (alu !== 4'd13 || m457 !== 1'b1 || m13 !== 1'b1 || m2 !== 1'b1) begin
          n_fail++;
          $display("FAIL lui_exec: ALU=%0d M457=%b M13=%b M2=%b, required 13 1 1 1", alu, m457, m13, m2);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (alu !== 4'd0 || m2 !== 1'b0 || m457 !== 1'b0) begin
          n_fail++;
          $display("FAIL fetch_mux: ALU=%0d M2=%b M457=%b, required 0 0 0", alu, m2, m457);
        end
      end
      if (i == 7) begin
        n_checks++;
        if (wr_en !== 1'b1 || alu !== 4'd4 || m2 !== 1'b1 || m13 !== 1'b0 || wr_en_rf !== 1'b0) begin
          n_fail++;
          $display("FAIL sw_mem_sel: Wr_en=%b ALU=%0d M2=%b M13=%b Wr_en_rf=%b, required 1 4 1 0 0",
                   wr_en, alu, m2, m13, wr_en_rf);
        end
      end
    end
  endtask

  task automatic test_illegal;
    int bad = 0;
    do_reset;
    mem_ready = 1'b1; opcode5 = 5'b10000;
    next_cycle;
    next_cycle;
    #1;
    n_checks++;
    if (state5 !== 3'd7 || illegal5 !== 1'b1 || timeout5 !== 1'b0) begin
      n_fail++;
      $display("FAIL ill_trap: state=%0d illegal=%b timeout=%b, required 7 1 0", state5, illegal5, timeout5);
    end
    for (int i = 0; i < 20; i++) begin
      next_cycle;
      #1;
      if (state5 !== 3'd7 || mem_req5 !== 1'b0 || pc_flag5 !== 1'b0 || wr_en_rf5 !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ill_stay: %0d cycles out of TRAP or with strobes, required 0", bad);
    end
    reset2 = 1'b0;
    #1;
    n_checks++;
    if (state5 !== 3'd0 || illegal5 !== 1'b0) begin
      n_fail++;
      $display("FAIL ill_reset: state=%0d illegal=%b, required 0 0", state5, illegal5);
    end
    reset2 = 1'b1;
  endtask

  initial begin
    reset = 1'b0; reset2 = 1'b0; mem_ready = 1'b0; Eq = 1'b0; opcode = 4'd0; opcode5 = 5'd0;
    test_reset;
    test_add;
    test_branch;
    test_lw;
    test_timeout;
    test_back_to_back;
    test_illegal;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_mc.md
Name: control_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle CPU control unit.
- Sequences FETCH/DECODE/EXEC/MEM/WB with a ready handshake to instruction/data memory.
- Counts memory wait-states with a programmable timeout, and traps on illegal opcodes or bus timeout.
- Drives the datapath mux selects, ALU code, PC and register-file/memory write enables.

Parameters:
- OPCODE_W, 4: opcode width. Values with any bit above bit 3 set are illegal.
- ALU_W, 4: ALU control width. The 4-bit code is zero-extended to this width.
- MEM_TIMEOUT, 15: maximum wait cycles in FETCH/MEM before trapping. 0 disables the timeout.
- CNT_W, 4: wait-counter width. Must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- opcode  in  OPCODE_W  instruction opcode, valid in DECODE
- Eq  in  1  ALU equality flag, valid in EXEC
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access active (FETCH, MEM)
- instruction_flag  out  1  current access is an instruction fetch
- pc_flag  out  1  PC increment strobe
- change_address_flag  out  1  load branch/jump target into PC
- Wr_en_rf  out  1  register-file write
- Wr_en  out  1  data-memory write (SW in MEM)
- M13  out  1  rf write address: 0=rd, 1=rt (ADDI, LUI, LW)
- M2  out  1  ALU B: 0=register, 1=immediate (ADDI, LUI, SL, SR, LW, SW)
- M457  out  1  upper-immediate path (LUI)
- M6  out  1  writeback source: 0=ALU, 1=memory (LW)
- ALU  out  ALU_W  ALU operation code
- state  out  3  FSM state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7
- timeout  out  1  sticky; trap cause was a bus timeout
- illegal  out  1  sticky; trap cause was an illegal opcode

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH; op_q=0; wait counter=0.
  - timeout=0, illegal=0.
  - All strobes and mux outputs are 0 while reset is low.
  - Reset mid-access abandons the access immediately.
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NOT, 4 ADD, 5 SUB, 6 CMP, 7 J, 8 BEQ, 9 BNE, A SL, B SR, C ADDI, D LUI, E LW, F SW.
- FETCH:
  - Outputs: mem_req=1, instruction_flag=1.
  - pc_flag = mem_ready (Mealy, single pulse).
  - mem_ready=1 -> DECODE.
- DECODE:
  - op_q <= opcode.
  - Illegal opcode -> TRAP with illegal<=1; otherwise -> EXEC.
- EXEC:
  - J: change_address_flag=1, -> FETCH.
  - BEQ: change_address_flag=Eq, -> FETCH.
  - BNE: change_address_flag=!Eq, -> FETCH.
  - CMP -> FETCH (flags only, no writeback).
  - LW, SW -> MEM.
  - All others -> WB.
- MEM:
  - mem_req=1; Wr_en=1 for SW, held until mem_ready.
  - On mem_ready: SW -> FETCH, LW -> WB.
- WB: Wr_en_rf=1 for exactly one cycle, -> FETCH.
- Mux selects and ALU are decoded from op_q in DECODE(next)/EXEC/MEM/WB. They are 0 in FETCH and TRAP.
- ALU code per instruction:
  - ALU ops 0-6, SL, SR and LUI: ALU = the opcode.
  - ADDI, LW, SW: ADD (4).
  - BEQ, BNE: SUB (5).
  - J: 0.
- Wait counter:
  - Increments each FETCH/MEM cycle with mem_ready=0.
  - Clears on any state change.
  - Reaching MEM_TIMEOUT with mem_ready still 0 -> TRAP with timeout<=1.
  - mem_ready arriving in the same cycle the counter reaches MEM_TIMEOUT wins: no trap.
  - Counter saturates and never wraps.
- TRAP: all strobes 0, mem_req=0. The FSM stays in TRAP until reset.
- Latency with zero wait-states (mem_ready=1 throughout):
  - ALU/ADDI/LUI: 4 cycles.
  - J, branches, CMP: 3 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.

Test Plan:
- Reset low mid-MEM of SW -> Wr_en and mem_req drop to 0 asynchronously. After release: state=0, pc_flag=0 until mem_ready.
- ADD with mem_ready=1 constantly -> state sequence 0,1,2,4,0. ALU=4 in EXEC/WB. Wr_en_rf=1 exactly one cycle; one pc_flag pulse.
- BEQ Eq=1 -> change_address_flag=1 in EXEC. BEQ Eq=0 -> 0. BNE Eq=0 -> 1. No Wr_en_rf in any case.
- LW with mem_ready low for 3 cycles in MEM -> stays in MEM 4 cycles. Then WB with M6=1, M13=1, M2=1, ALU=4.
- Hold mem_ready=0 in FETCH (MEM_TIMEOUT=15) -> TRAP (state=7) with timeout=1 after 15 cycles. Repeat with mem_ready asserted at cycle 15 -> DECODE, no trap.
- OPCODE_W=5, opcode=5'b10000 -> TRAP with illegal=1. The FSM remains in TRAP for 20 cycles until reset.
